piso_serial_tx: RTL and testbench
=================================

// Module: piso_serial_tx
// PURPOSE
//   Parallel-in serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load
//   handshake and shifts it out one bit per clk on sout, qualified by sout_valid.
//   Built from dff-style state registers; it is the transmit end paired with the
//   serial-in/parallel-out receiver in the sequential-circuits library.
// PARAMETERS
//   WIDTH      8   bits per word, >= 2; bit counter is $clog2(WIDTH) bits wide
//   MSB_FIRST  1   1: din[WIDTH-1] is sent first; 0: din[0] is sent first
// PORTS
//   clk         input   1      rising-edge clock
//   rst         input   1      asynchronous, active-low reset (rst==0 resets)
//   din         input   WIDTH  parallel word; sampled only on an accepted load
//   load_valid  input   1      source requests a load
//   load_ready  output  1      block can accept a load this cycle
//   sout        output  1      serial data; 0 when sout_valid==0
//   sout_valid  output  1      sout carries a data bit this cycle
//   busy        output  1      high in SHIFT and DONE
//   done        output  1      one-cycle pulse after the last bit
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low. rst==0 forces, without waiting for clk:
//     state=IDLE, shreg=0, cnt=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
//   - FSM states are IDLE, SHIFT and DONE. All outputs are decoded from registers
//     (no combinational path from inputs):
//       load_ready = (state==IDLE)
//       sout_valid = (state==SHIFT)
//       busy       = (state!=IDLE)
//       done       = (state==DONE)
//   - Transitions:
//       IDLE  -> SHIFT  on an edge with load_valid && load_ready; shreg<=din, cnt<=0
//       SHIFT -> SHIFT  while cnt!=WIDTH-1; cnt<=cnt+1, shreg shifts toward the output bit
//                       (left if MSB_FIRST, else right), zero filled
//       SHIFT -> DONE   on the edge where cnt==WIDTH-1
//       DONE  -> IDLE   unconditionally on the next edge
//   - sout is shreg[WIDTH-1] if MSB_FIRST, else shreg[0], gated by sout_valid.
//   - Latency: the first bit is valid in the cycle after the accepting edge. The bits
//     occupy exactly WIDTH consecutive cycles, done follows in cycle WIDTH+1, and
//     load_ready returns in cycle WIDTH+2. Minimum spacing between accepted loads is
//     WIDTH+2 cycles.
//   - load_valid while load_ready==0 is ignored. No queueing, and din changes have no
//     effect on the word in flight.
//   - load_valid held high continuously: a new word is accepted on every IDLE cycle,
//     giving back-to-back frames with the two-cycle gap above.
//   - Reset asserted mid-frame aborts the frame immediately. The partial word is
//     discarded and no done pulse is produced. After release, the first accepted
//     load starts a fresh frame.
//   - cnt never exceeds WIDTH-1. No wrap-around other than the reload to 0 on accept.
// TESTING
//   1. Reset: rst=0 at a random mid-cycle time -> all outputs at reset values before
//      the next clk edge; load_ready=1.
//   2. WIDTH=8, MSB_FIRST=1, din=8'hA5 with a one-cycle load_valid -> sout=1,0,1,0,0,1,0,1
//      on cycles 1..8 with sout_valid=1, done=1 on cycle 9 only, load_ready=1 on cycle 10.
//   3. MSB_FIRST=0, din=8'hA5 -> sout=1,0,1,0,0,1,0,1 (LSB first, same sequence);
//      din=8'h01 -> 1,0,0,0,0,0,0,0.
//   4. load_valid held high with din changing every cycle -> only words present on
//      IDLE cycles are sent, frames are exactly 10 cycles apart, and mid-frame din
//      changes never appear on sout.
//   5. Reset pulse after bit 4 of 8'hFF -> sout_valid drops immediately, no done pulse;
//      the next load of 8'h3C is sent intact.
//   6. WIDTH=4, din=4'b1001 -> four bits then done on cycle 5; self-checking SIPO
//      loopback compares 200 $random words.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock, followed by a single-cycle done pulse.
`timescale 1ns/1ps

module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shift direction moves the next bit to send into the output tap, zero filled.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt = SHIFT;
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (MSB_FIRST) begin
                        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load_ready = (state == IDLE);
    assign sout_valid = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign sout       = sout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: MSB/LSB-first 8-bit instances and a 4-bit instance
// with a SIPO-style loopback of random words.
`timescale 1ns/1ps

module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] din_m, din_l;
    logic [3:0] din_4;
    logic       lv_m, lv_l, lv_4;
    logic       lr_m, so_m, sv_m, bz_m, dn_m;
    logic       lr_l, so_l, sv_l, bz_l, dn_l;
    logic       lr_4, so_4, sv_4, bz_4, dn_4;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din_m), .load_valid(lv_m), .load_ready(lr_m),
        .sout(so_m), .sout_valid(sv_m), .busy(bz_m), .done(dn_m)
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(lr_l),
        .sout(so_l), .sout_valid(sv_l), .busy(bz_l), .done(dn_l)
    );

    piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .din(din_4), .load_valid(lv_4), .load_ready(lr_4),
        .sout(so_4), .sout_valid(sv_4), .busy(bz_4), .done(dn_4)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Observation vector is {load_ready, sout, sout_valid, busy, done}.
    task automatic get_obs(input int sel, output logic [4:0] o);
        case (sel)
            0:       o = {lr_m, so_m, sv_m, bz_m, dn_m};
            1:       o = {lr_l, so_l, sv_l, bz_l, dn_l};
            default: o = {lr_4, so_4, sv_4, bz_4, dn_4};
        endcase
    endtask

    task automatic apply_stimulus(input int sel, input logic lv, input logic [7:0] word);
        case (sel)
            0:       begin lv_m = lv; din_m = word;      end
            1:       begin lv_l = lv; din_l = word;      end
            default: begin lv_4 = lv; din_4 = word[3:0]; end
        endcase
    endtask

    // seq holds the expected bits in transmit order, first bit at seq[width-1].
    task automatic run_frame(input int sel, input logic [7:0] word, input logic [7:0] seq,
                             input int width, input bit poke, input string name);
        logic [4:0] o;
        @(negedge clk);
        get_obs(sel, o);
        check_output({name, " idle"}, o, 5'b10000);
        apply_stimulus(sel, 1'b1, word);
        @(posedge clk);
        #1 apply_stimulus(sel, 1'b0, ~word);
        for (int i = 1; i <= width; i++) begin
            @(negedge clk);
            get_obs(sel, o);
            check_output($sformatf("%s bit%0d", name, i), o, {1'b0, seq[width-i], 3'b110});
            if (poke && i == 3) apply_stimulus(sel, 1'b1, 8'h00);
            if (poke && i == 4) apply_stimulus(sel, 1'b0, 8'h00);
        end
        @(negedge clk);
        get_obs(sel, o);
        check_output({name, " done"}, o, 5'b00011);
        @(negedge clk);
        get_obs(sel, o);
        check_output({name, " ready"}, o, 5'b10000);
    endtask

    function automatic logic [7:0] pat(input int c);
        return 8'(c * 29 + 8'h5A);
    endfunction

    initial begin
        logic [4:0] o;
        logic [7:0] w;
        logic [3:0] w4, rx;
        int         nb, d, m;

        rst = 1'b1;
        apply_stimulus(0, 1'b0, 8'h00);
        apply_stimulus(1, 1'b0, 8'h00);
        apply_stimulus(2, 1'b0, 8'h00);
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            get_obs(s, o);
            check_output($sformatf("reset inst%0d", s), o, 5'b10000);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_frame(0, 8'hA5, 8'b10100101, 8, 1'b1, "msb_a5");
        run_frame(1, 8'hA5, 8'b10100101, 8, 1'b0, "lsb_a5");
        run_frame(1, 8'h01, 8'b10000000, 8, 1'b0, "lsb_01");

        // load_valid held high: a word is taken every 10 cycles, din changes each cycle.
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            m = c % 10;
            w = pat((c / 10) * 10);
            get_obs(0, o);
            if (m == 0)      check_output($sformatf("held c%0d", c), o, 5'b10000);
            else if (m == 9) check_output($sformatf("held c%0d", c), o, 5'b00011);
            else             check_output($sformatf("held c%0d", c), o, {1'b0, w[8-m], 3'b110});
            apply_stimulus(0, 1'b1, pat(c));
            @(negedge clk);
        end
        get_obs(0, o);
        check_output("held end ready", o, 5'b10000);
        apply_stimulus(0, 1'b0, 8'h00);
        @(negedge clk);
        get_obs(0, o);
        check_output("held end idle", o, 5'b10000);

        // Mid-frame reset after bit 4 of 8'hFF.
        apply_stimulus(0, 1'b1, 8'hFF);
        @(posedge clk);
        #1 apply_stimulus(0, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            get_obs(0, o);
            check_output($sformatf("ff bit%0d", i), o, 5'b01110);
        end
        @(posedge clk);
        d = $urandom_range(1, 7);
        #d rst = 1'b0;
        #1;
        get_obs(0, o);
        check_output("abort async", o, 5'b10000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            get_obs(0, o);
            check_output($sformatf("abort hold%0d", i), o, 5'b10000);
        end
        rst = 1'b1;
        @(negedge clk);
        get_obs(0, o);
        check_output("abort no done", o, 5'b10000);
        run_frame(0, 8'h3C, 8'b00111100, 8, 1'b0, "msb_3c");

        run_frame(2, 8'h09, 8'h09, 4, 1'b0, "w4_1001");

        // Loopback: reassemble each 4-bit frame as a receiver would.
        for (int k = 0; k < 200; k++) begin
            w4 = 4'($urandom);
            @(negedge clk);
            apply_stimulus(2, 1'b1, {4'h0, w4});
            @(posedge clk);
            #1 apply_stimulus(2, 1'b0, 8'h00);
            rx = '0;
            nb = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (sv_4) begin
                    rx = {rx[2:0], so_4};
                    nb++;
                end
            end
            @(negedge clk);
            check_output($sformatf("loop%0d word", k), {nb[3:0], dn_4, rx}, {4'd4, 1'b1, w4});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
